// File: rtl/lzc_sched_pkg.sv
// Shared definitions for the leading-zero-count request scheduler:
// FSM state encodings, default vector geometry and the timeout result code.
package lzc_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RESP    = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_WORD  = 4;

  localparam int              ZEROS_W   = 9;
  localparam logic [ZEROS_W-1:0] ERR_ZEROS = 9'h1FF;

  // Index arithmetic modulo n for operands already in [0, n).
  function automatic int wrap_idx(input int base, input int ofs, input int n);
    int s;
    s = base + ofs;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/lzc_rr_arb.sv
// Combinational round-robin selector: scans requesters starting at ptr_i
// and returns the first active one as a one-hot grant plus its index.
module lzc_rr_arb
  import lzc_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int RID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [RID_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [RID_W-1:0] idx_o,
  output logic             valid_o
);

  logic [RID_W-1:0] cand;

  // Priority scan from ptr_i upwards, wrapping at NREQ.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = RID_W'(wrap_idx(int'(ptr_i), k, NREQ));
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/lzc_sched.sv
// Round-robin scheduler in front of a byte-serial leading-zero-count engine.
// A granted requester's vector is streamed MSB byte first; the engine's count
// (or a timeout code) is returned tagged with the requester index, followed
// by a fixed recovery gap before the next grant.
module lzc_sched
  import lzc_sched_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int WORD    = DEF_WORD,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 8,
  parameter int RECOV   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req_i,
  input  logic [NREQ-1:0]              req_mode_i,
  input  logic [NREQ*WORD*WIDTH-1:0]   req_data_i,
  output logic [NREQ-1:0]              gnt_o,
  output logic                         rvalid_o,
  output logic [$clog2(NREQ)-1:0]      rid_o,
  output logic [8:0]                   rzeros_o,
  output logic                         rerr_o,
  output logic                         lz_ivalid_o,
  output logic [WIDTH-1:0]             lz_data_o,
  output logic                         lz_mode_o,
  input  logic [8:0]                   lz_zeros_i,
  input  logic                         lz_ovalid_i
);

  localparam int RID_W  = $clog2(NREQ);
  localparam int VEC_W  = WORD * WIDTH;
  localparam int BCNT_W = $clog2(WORD) + 1;
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam int RCNT_W = $clog2(RECOV + 1);

  state_e              state_q;
  logic [RID_W-1:0]    ptr_q;
  logic [RID_W-1:0]    cur_id_q;
  logic [VEC_W-1:0]    shreg_q;
  logic [BCNT_W-1:0]   byte_cnt_q;
  logic [TCNT_W-1:0]   tmo_cnt_q;
  logic [RCNT_W-1:0]   rec_cnt_q;

  logic [NREQ-1:0]     gnt_q;
  logic                rvalid_q;
  logic [RID_W-1:0]    rid_q;
  logic [8:0]          rzeros_q;
  logic                rerr_q;
  logic                lz_ivalid_q;
  logic [WIDTH-1:0]    lz_data_q;
  logic                lz_mode_q;

  logic [NREQ-1:0]     win_gnt;
  logic [RID_W-1:0]    win_idx;
  logic                win_valid;
  logic [RID_W-1:0]    ptr_d;
  logic [VEC_W-1:0]    sel_data;
  logic                sel_mode;

  lzc_rr_arb #(
    .NREQ  (NREQ),
    .RID_W (RID_W)
  ) u_arb (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (win_gnt),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  // Pointer moves just past the winner so it has lowest priority next round.
  assign ptr_d = RID_W'(wrap_idx(int'(win_idx), 1, NREQ));

  // Pick the winner's vector slice and mode bit.
  always_comb begin
    sel_data = '0;
    sel_mode = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == RID_W'(i)) begin
        sel_data = req_data_i[i*VEC_W +: VEC_W];
        sel_mode = req_mode_i[i];
      end
    end
  end

  // Scheduler FSM; every externally visible signal is a register written here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cur_id_q    <= '0;
      shreg_q     <= '0;
      byte_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      rec_cnt_q   <= '0;
      gnt_q       <= '0;
      rvalid_q    <= 1'b0;
      rid_q       <= '0;
      rzeros_q    <= '0;
      rerr_q      <= 1'b0;
      lz_ivalid_q <= 1'b0;
      lz_data_q   <= '0;
      lz_mode_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge register values regardless of statement order.
      gnt_q    <= '0;
      rvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_valid) begin
            gnt_q       <= win_gnt;
            ptr_q       <= ptr_d;
            cur_id_q    <= win_idx;
            // First byte goes out together with the grant pulse.
            lz_ivalid_q <= 1'b1;
            lz_data_q   <= sel_data[VEC_W-1 -: WIDTH];
            lz_mode_q   <= sel_mode;
            shreg_q     <= sel_data << WIDTH;
            byte_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            state_q     <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (lz_ovalid_i) begin
            // Engine finished early (mode 1): abandon remaining bytes.
            lz_ivalid_q <= 1'b0;
            lz_data_q   <= '0;
            lz_mode_q   <= 1'b0;
            rvalid_q    <= 1'b1;
            rid_q       <= cur_id_q;
            rzeros_q    <= lz_zeros_i;
            rerr_q      <= 1'b0;
            state_q     <= ST_RESP;
          end else if (byte_cnt_q == BCNT_W'(WORD - 1)) begin
            lz_ivalid_q <= 1'b0;
            lz_data_q   <= '0;
            lz_mode_q   <= 1'b0;
            tmo_cnt_q   <= '0;
            state_q     <= ST_WAIT;
          end else begin
            lz_data_q   <= shreg_q[VEC_W-1 -: WIDTH];
            shreg_q     <= shreg_q << WIDTH;
            byte_cnt_q  <= byte_cnt_q + BCNT_W'(1);
          end
        end

        ST_WAIT: begin
          if (lz_ovalid_i) begin
            rvalid_q <= 1'b1;
            rid_q    <= cur_id_q;
            rzeros_q <= lz_zeros_i;
            rerr_q   <= 1'b0;
            state_q  <= ST_RESP;
          end else if (tmo_cnt_q == TCNT_W'(TIMEOUT - 1)) begin
            rvalid_q <= 1'b1;
            rid_q    <= cur_id_q;
            rzeros_q <= ERR_ZEROS;
            rerr_q   <= 1'b1;
            state_q  <= ST_RESP;
          end else if (tmo_cnt_q != '1) begin
            tmo_cnt_q <= tmo_cnt_q + TCNT_W'(1);
          end
        end

        ST_RESP: begin
          rec_cnt_q <= '0;
          state_q   <= ST_RECOVER;
        end

        ST_RECOVER: begin
          // Engine outputs are deliberately ignored while recovering.
          if (rec_cnt_q == RCNT_W'(RECOV - 1)) begin
            state_q <= ST_IDLE;
          end else begin
            rec_cnt_q <= rec_cnt_q + RCNT_W'(1);
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign rvalid_o    = rvalid_q;
  assign rid_o       = rid_q;
  assign rzeros_o    = rzeros_q;
  assign rerr_o      = rerr_q;
  assign lz_ivalid_o = lz_ivalid_q;
  assign lz_data_o   = lz_data_q;
  assign lz_mode_o   = lz_mode_q;

endmodule

// File: doc/lzc_sched.md
LZC_SCHED -- requirements
Module: lzc_sched

Interface
REQ-001 Parameter WIDTH, default 8: bits per byte sent to the engine.
REQ-002 Parameter WORD, default 4: bytes per request vector.
REQ-003 Parameter NREQ, default 4: number of requesters; RID width is log2(NREQ).
REQ-004 Parameter TIMEOUT, default 8: maximum wait cycles for engine result after the last byte.
REQ-005 Parameter RECOV, default 2: engine idle cycles enforced after each response.
REQ-006 Ports, one per line:
- CLK  in  1  single clock; all state changes on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ  in  NREQ  per-requester request, level.
- REQ_MODE  in  NREQ  per-requester engine mode: 1 = stop at first nonzero byte, 0 = all WORD bytes.
- REQ_DATA  in  NREQ*WORD*WIDTH  per-requester vector; requester i occupies slice i; MSB byte is sent first.
- GNT  out  NREQ  one-hot acceptance pulse.
- RVALID  out  1  result strobe.
- RID  out  log2(NREQ)  requester index of the result.
- RZEROS  out  9  leading-zero count.
- RERR  out  1  engine timeout flag.
- LZ_IVALID  out  1  engine byte valid.
- LZ_DATA  out  WIDTH  engine byte.
- LZ_MODE  out  1  engine mode.
- LZ_ZEROS  in  9  engine count.
- LZ_OVALID  in  1  engine result valid.

Function
REQ-007 FSM states: IDLE, SEND, WAIT, RESP, RECOVER; all outputs are registered.
REQ-008 IDLE with |REQ: on that edge, select the winner round-robin, starting at index PTR.
- Capture the winner's REQ_DATA slice into a shift register and its REQ_MODE.
- Set GNT[winner] for exactly one cycle.
- Set PTR = (winner+1) mod NREQ.
- Clear the byte and timeout counters.
- Enter SEND.
REQ-009 IDLE with REQ=0: remain in IDLE.
REQ-010 SEND: each cycle LZ_IVALID=1, LZ_DATA = top byte of the shift register, and LZ_MODE = captured mode.
- The register shifts left by WIDTH per cycle.
- WORD bytes go out on WORD consecutive cycles.
- After the last byte, enter WAIT.
REQ-011 LZ_OVALID=1 in SEND: capture LZ_ZEROS, stop sending (LZ_IVALID=0 from the next cycle), and enter RESP.
REQ-012 WAIT: LZ_IVALID=0. On LZ_OVALID, capture LZ_ZEROS, set RERR=0 and enter RESP.
REQ-013 WAIT without LZ_OVALID for TIMEOUT cycles: enter RESP with RZEROS=9'h1FF and RERR=1.
REQ-014 RESP: RVALID=1 for exactly one cycle with RID, RZEROS and RERR valid; then enter RECOVER.
REQ-015 RECOVER: LZ_IVALID=0 for RECOV cycles; then IDLE. LZ_OVALID arriving in RECOVER or IDLE is ignored.
REQ-016 Forced-zero outputs:
- LZ_DATA=0 whenever LZ_IVALID=0.
- RZEROS, RID and RERR hold their last values when RVALID=0.
REQ-017 REQ changes outside IDLE are ignored. A REQ dropped before its GNT is never served.
REQ-018 A requester re-asserting REQ immediately after its GNT is served only after the other active requesters, per PTR.
REQ-019 The timeout counter saturates and never wraps. The byte counter is log2(WORD)+1 bits wide.

Reset
REQ-020 RST_N low, at any time including mid-transfer, immediately forces:
- state IDLE, PTR=0;
- GNT=0, RVALID=0, RID=0, RZEROS=0, RERR=0;
- LZ_IVALID=0, LZ_DATA=0, LZ_MODE=0;
- shift register and all counters cleared.
REQ-021 After reset release, the first grant is evaluated on the first rising edge.

Structure
REQ-022 A shared package holds:
- state encodings (IDLE=0, SEND=1, WAIT=2, RESP=3, RECOVER=4);
- WIDTH/WORD defaults;
- the 9'h1FF error code.
REQ-023 One sub-module, lzc_rr_arb, holds the combinational round-robin selector (REQ, PTR -> one-hot winner, index). It is instantiated once.

Verification
REQ-024 Mode 0, REQ=0001, data 32'h00001FFF:
- GNT=0001 for one cycle;
- LZ_DATA = 00, 00, 1F, FF on 4 consecutive cycles with LZ_IVALID=1;
- engine returns 19, giving RVALID=1, RID=0, RZEROS=19, RERR=0.
REQ-025 Mode 1, data 32'h00800000, engine OVALID during the 2nd byte:
- only bytes 00 and 80 are sent;
- RZEROS=8, RID=0.
REQ-026 REQ=1111 held continuously, after reset: grants are issued in order 0, 1, 2, 3, 0, each separated by the full SEND/WAIT/RESP/RECOVER sequence.
REQ-027 Engine silent: RESP occurs 8 cycles after the last byte, with RZEROS=9'h1FF and RERR=1; then RECOVER lasts 2 cycles.
REQ-028 RST_N asserted during the 3rd SEND byte: all outputs are 0 immediately. After release with REQ=0100, GNT=0100 and a complete fresh 4-byte sequence follows.
